alu_share_ctrl: RTL
===================

// Module: alu_share_ctrl
// PURPOSE
//  Two-port controller that shares one ALU (FORWARD/ADD/AND/OR, 3-bit SELECT) between two requesters.
//  - Arbitrates round-robin, latches operands, drives the ALU, waits a fixed settle time, then captures RESULT.
//  - Returns RESULT on a single response channel tagged with the requester ID.
//  - Sits between the datapath requesters (instruction path, aux unit) and the shared ALU instance.
// PARAMETERS
//  WIDTH     8  operand/result width (ALU is 8-bit; keep 8 unless the ALU is widened)
//  ALU_WAIT  2  clock cycles the ALU is given to settle after operands are driven (>=1)
// PORTS
//  CLK          in   1      clock; all state updates on posedge CLK
//  RESET        in   1      asynchronous, active-low reset (RESET==0 resets immediately)
//  REQ0_VALID   in   1      requester 0 has an operation pending
//  REQ0_READY   out  1      controller accepts requester 0 this cycle
//  REQ0_DATA1   in   WIDTH  requester 0 operand 1
//  REQ0_DATA2   in   WIDTH  requester 0 operand 2
//  REQ0_SELECT  in   3      requester 0 ALU opcode
//  REQ1_*       -    -      same five signals for requester 1
//  ALU_DATA1    out  WIDTH  to ALU DATA1
//  ALU_DATA2    out  WIDTH  to ALU DATA2
//  ALU_SELECT   out  3      to ALU SELECT
//  ALU_RESULT   in   WIDTH  from ALU RESULT
//  RSP_VALID    out  1      response available
//  RSP_READY    in   1      consumer takes the response
//  RSP_ID       out  1      requester the response belongs to
//  RSP_RESULT   out  WIDTH  captured ALU result
//  RSP_ERR      out  1      1 = reserved opcode (3'b100..3'b111)
// BEHAVIOUR
//  Reset values
//   - state=IDLE; ALU_DATA1/ALU_DATA2=0; ALU_SELECT=3'b000.
//   - RSP_VALID=0, RSP_ID=0, RSP_RESULT=0, RSP_ERR=0; wait counter=0.
//   - LAST_GRANT=1, so REQ0 wins the first tie.
//  FSM: IDLE -> EXEC -> RESP -> IDLE
//   - IDLE
//     - Winner = the only valid requester; on a tie, the one != LAST_GRANT.
//     - REQx_READY=1 combinationally for the winner only; all READY=0 outside IDLE.
//     - On VALID&&READY: latch DATA1/DATA2/SELECT into the ALU_* regs, LAST_GRANT<=winner, counter<=ALU_WAIT-1, go to EXEC.
//   - EXEC
//     - ALU_* held stable.
//     - counter!=0: decrement.
//     - counter==0: RSP_RESULT<=ALU_RESULT, RSP_ID<=LAST_GRANT, RSP_ERR<=0, RSP_VALID<=1, go to RESP.
//     - Reserved SELECT: the EXEC wait still runs, but RSP_RESULT<=0 and RSP_ERR<=1 (ALU output ignored).
//   - RESP
//     - RSP_* held stable while RSP_READY=0 (no drop, no change).
//     - RSP_VALID&&RSP_READY: RSP_VALID<=0, go to IDLE.
//  Latency and throughput
//   - Accept edge N -> RSP_VALID high after edge N+ALU_WAIT.
//   - Without the bypass feature: one IDLE cycle between transactions, so peak rate is 1 op per ALU_WAIT+2 cycles.
//  Other rules
//   - Requester VALID may drop before acceptance; nothing is latched.
//   - A request is never accepted while a response is pending, except via the bypass feature.
//   - ALU_* keep their last values in IDLE/RESP; no spurious toggling.
//   - RESET low in any state: immediate return to the reset values; an in-flight op is discarded with no response.
// CONFIGURATION
//  ALU_SHARE_BYPASS_EN
//   - Defined: in RESP with RSP_READY=1, the arbitration winner also gets READY=1 that same cycle.
//     - A handshake then goes straight to EXEC (zero bubble).
//     - Round-robin uses the LAST_GRANT value before the update.
//   - Undefined: READY only in IDLE, as above.
// TESTING
//  - REQ0 ADD 8'h55,8'h0F, ALU_WAIT=2 -> RSP_VALID 2 cycles after accept; RESULT=8'h64, ID=0, ERR=0.
//  - REQ0 and REQ1 both valid from reset (REQ0 AND 8'hF0,8'h3C; REQ1 OR same)
//    -> REQ0 served first (8'h30), then REQ1 (8'hFC); order alternates thereafter.
//  - REQ1 SELECT=3'b101 -> RSP_RESULT=8'h00, RSP_ERR=1, ID=1.
//  - RSP_READY low 5 cycles -> RSP_VALID/RESULT stable throughout; both READY=0; no new accept.
//  - RESET pulsed low mid-EXEC -> all outputs at reset values immediately; no response issued;
//    - next REQ0 FORWARD 8'hA5 -> 8'hA5.
//  - With ALU_SHARE_BYPASS_EN: back-to-back REQ0 ops with RSP_READY=1 -> accept every ALU_WAIT+1 cycles.

Source files
------------

// File: rtl/alu_share_if.sv
// Bundle of requester, ALU and response signals around the shared-ALU controller.
// The controller takes the slave view; requesters, ALU and response consumer take the master view.
interface alu_share_if #(
  parameter int unsigned Width = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [Width-1:0] req0_data1;
  logic [Width-1:0] req0_data2;
  logic [2:0]       req0_select;

  logic             req1_valid;
  logic             req1_ready;
  logic [Width-1:0] req1_data1;
  logic [Width-1:0] req1_data2;
  logic [2:0]       req1_select;

  logic [Width-1:0] alu_data1;
  logic [Width-1:0] alu_data2;
  logic [2:0]       alu_select;
  logic [Width-1:0] alu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [Width-1:0] rsp_result;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_data1, req0_data2, req0_select,
    output req1_valid, req1_data1, req1_data2, req1_select,
    output alu_result, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_data1, alu_data2, alu_select,
    input  rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport slave (
    input  req0_valid, req0_data1, req0_data2, req0_select,
    input  req1_valid, req1_data1, req1_data2, req1_select,
    input  alu_result, rsp_ready,
    output req0_ready, req1_ready,
    output alu_data1, alu_data2, alu_select,
    output rsp_valid, rsp_id, rsp_result, rsp_err
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one ALU between two requesters, one tagged response channel.
// Optional ALU_SHARE_BYPASS_EN: accept a new request in the same cycle a response is taken.
module alu_share_ctrl #(
  parameter int unsigned Width   = 8,
  parameter int unsigned AluWait = 2
) (
  input logic        clk_i,
  input logic        rst_ni,
  alu_share_if.slave bus
);

  localparam int unsigned CntW = (AluWait > 1) ? $clog2(AluWait) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(AluWait - 1);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] alu_data1_q, alu_data1_d;
  logic [Width-1:0] alu_data2_q, alu_data2_d;
  logic [2:0]       alu_select_q, alu_select_d;
  logic             last_grant_q, last_grant_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [Width-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_err_q, rsp_err_d;

  logic winner;
  logic grant_ok;
  logic accept;
  logic req0_ready;
  logic req1_ready;
  logic reserved;

  always_comb begin
    state_d      = state_q;
    alu_data1_d  = alu_data1_q;
    alu_data2_d  = alu_data2_q;
    alu_select_d = alu_select_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;

    // On a tie the requester that was not granted last time wins.
    winner   = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
    grant_ok = (state_q == StIdle);
`ifdef ALU_SHARE_BYPASS_EN
    grant_ok = grant_ok | ((state_q == StResp) & bus.rsp_ready);
`endif
    accept     = grant_ok & (bus.req0_valid | bus.req1_valid);
    req0_ready = grant_ok & bus.req0_valid & ~winner;
    req1_ready = grant_ok & bus.req1_valid & winner;
    reserved   = alu_select_q[2];

    unique case (state_q)
      StIdle: ;
      StExec: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          rsp_result_d = reserved ? '0 : bus.alu_result;
          rsp_err_d    = reserved;
          rsp_id_d     = last_grant_q;
          rsp_valid_d  = 1'b1;
          state_d      = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Covers both the idle accept and the bypass accept out of StResp.
    if (accept) begin
      alu_data1_d  = winner ? bus.req1_data1  : bus.req0_data1;
      alu_data2_d  = winner ? bus.req1_data2  : bus.req0_data2;
      alu_select_d = winner ? bus.req1_select : bus.req0_select;
      last_grant_d = winner;
      cnt_d        = CntInit;
      state_d      = StExec;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      alu_data1_q  <= '0;
      alu_data2_q  <= '0;
      alu_select_q <= 3'b000;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_data1_q  <= alu_data1_d;
      alu_data2_q  <= alu_data2_d;
      alu_select_q <= alu_select_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req0_ready = req0_ready;
  assign bus.req1_ready = req1_ready;
  assign bus.alu_data1  = alu_data1_q;
  assign bus.alu_data2  = alu_data2_q;
  assign bus.alu_select = alu_select_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule
